poly_decode_ctrl: RTL
=====================

POLY_DECODE_CTRL -- requirements
Module: poly_decode_ctrl

Interface
REQ-001 Parameter ELL, default 12, coefficient bit width; legal range 1..12.
REQ-002 Parameter NUM_COEFFS, default 256, coefficients per polynomial; total input bytes = NUM_COEFFS*ELL/8.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  begin decoding one polynomial; sampled only in IDLE.
REQ-006 in_byte  input  8  serialized encoded byte.
REQ-007 in_valid  input  1  in_byte valid.
REQ-008 in_ready  output  1  controller accepts in_byte this cycle.
REQ-009 coeff  output  ELL  decoded coefficient.
REQ-010 coeff_idx  output  8  index of coeff, 0..NUM_COEFFS-1.
REQ-011 coeff_valid  output  1  coeff/coeff_idx valid.
REQ-012 coeff_ready  input  1  consumer accepts coeff.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  one-cycle pulse after last coefficient handshake.
REQ-015 err  output  1  sticky range error (present only with DECODE_MODQ_CHECK_EN; otherwise tied 0).

Function
REQ-016 States: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on handshake of coefficient NUM_COEFFS-1; DONE->IDLE unconditionally next cycle.
REQ-017 On IDLE->RUN: bit buffer (19 bits), bit count, byte counter, coefficient index cleared; err cleared.
REQ-018 Bit order LSB-first: byte n bit j is stream bit 8n+j; coefficient k = stream bits k*ELL..k*ELL+ELL-1, bit k*ELL is coefficient LSB.
REQ-019 in_ready = RUN and bit count < ELL and bytes consumed < total; byte accepted on in_valid&in_ready, appended above existing bits, count += 8.
REQ-020 coeff_valid = RUN and bit count >= ELL; coeff = low ELL buffer bits; in_ready and coeff_valid never high together.
REQ-021 On coeff_valid&coeff_ready: buffer shifts right by ELL, count -= ELL, coeff_idx increments; coeff/coeff_idx held stable while coeff_valid high and coeff_ready low.
REQ-022 No bits discarded; count returns to 0 exactly after final coefficient.
REQ-023 Latency: start in cycle t -> in_ready may assert cycle t+1; accepted byte yielding >= ELL bits -> coeff_valid next cycle.
REQ-024 start in RUN or DONE ignored; in_valid outside RUN ignored, in_ready low.
REQ-025 done high only in DONE state; busy high only in RUN.

Reset
REQ-026 rst_n low: state IDLE immediately; in_ready, coeff_valid, busy, done, err = 0; coeff, coeff_idx = 0; buffer and counters = 0.
REQ-027 Reset mid-RUN abandons polynomial; no done pulse; next start restarts from byte 0.

Configuration
REQ-028 Macro DECODE_MODQ_CHECK_EN defined: on each coefficient handshake with ELL == 12 and coeff >= 3329, err sets and holds until next start or reset; coefficient still output unmodified.
REQ-029 Macro undefined: no comparator logic; err constant 0.

Verification
REQ-030 ELL=1, start, byte 0xA5 -> coeffs idx0..7 = 1,0,1,0,0,1,0,1; after 32 bytes/256 coeffs, done pulses once, state IDLE.
REQ-031 ELL=12, bytes 0x01,0xF2,0xFF -> coeff0=0x201, coeff1=0xFFF; with DECODE_MODQ_CHECK_EN err=1 after idx1 handshake, without err=0.
REQ-032 ELL=12, coeff_ready held low 10 cycles on idx0 -> coeff_valid stays 1, coeff=0x201 stable, in_ready 0, no byte consumed.
REQ-033 Start pulsed during RUN at idx 100 -> ignored; sequence completes normally with 256 coeffs, one done.
REQ-034 rst_n low at idx 50 -> all outputs 0 same cycle (async); new start then byte 0xA5 (ELL=1) -> idx0 coeff=1.

Source files
------------

// File: rtl/poly_decode_ctrl.sv
// Unpacks an LSB-first byte stream into NUM_COEFFS coefficients of ELL bits each.
// Optional DECODE_MODQ_CHECK_EN adds a sticky err flag for 12-bit coefficients >= 3329.
module poly_decode_ctrl #(
    parameter int unsigned ELL        = 12,
    parameter int unsigned NUM_COEFFS = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [7:0]     in_byte,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [ELL-1:0] coeff,
    output logic [7:0]     coeff_idx,
    output logic           coeff_valid,
    input  logic           coeff_ready,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int unsigned BUF_W       = 19;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned IDX_W       = 8;
    localparam int unsigned TOTAL_BYTES = NUM_COEFFS * ELL / 8;
    localparam int unsigned BYTE_W      = $clog2(TOTAL_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-1:0]  bytes_q, bytes_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic               coeff_valid_q, coeff_valid_d;
    logic [ELL-1:0]     coeff_q, coeff_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               byte_acc;
    logic               coeff_hs;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        bytes_d  = bytes_q;
        idx_d    = idx_q;
        byte_acc = in_valid & in_ready_q;
        coeff_hs = coeff_valid_q & coeff_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    buf_d   = '0;
                    cnt_d   = '0;
                    bytes_d = '0;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                // Accept and emit are mutually exclusive since ready/valid never overlap.
                if (byte_acc) begin
                    buf_d   = buf_q | (BUF_W'(in_byte) << cnt_q);
                    cnt_d   = cnt_q + CNT_W'(8);
                    bytes_d = bytes_q + BYTE_W'(1);
                end else if (coeff_hs) begin
                    buf_d = buf_q >> ELL;
                    cnt_d = cnt_q - CNT_W'(ELL);
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they align with the state.
        busy_d        = (state_d == S_RUN);
        done_d        = (state_d == S_DONE);
        in_ready_d    = (state_d == S_RUN) && (cnt_d < CNT_W'(ELL))
                        && (bytes_d < BYTE_W'(TOTAL_BYTES));
        coeff_valid_d = (state_d == S_RUN) && (cnt_d >= CNT_W'(ELL));
        coeff_d       = buf_d[ELL-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            buf_q         <= '0;
            cnt_q         <= '0;
            bytes_q       <= '0;
            idx_q         <= '0;
            in_ready_q    <= 1'b0;
            coeff_valid_q <= 1'b0;
            coeff_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            bytes_q       <= bytes_d;
            idx_q         <= idx_d;
            in_ready_q    <= in_ready_d;
            coeff_valid_q <= coeff_valid_d;
            coeff_q       <= coeff_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign coeff_valid = coeff_valid_q;
    assign coeff       = coeff_q;
    assign coeff_idx   = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef DECODE_MODQ_CHECK_EN
    localparam int unsigned MODQ = 3329;

    logic err_q, err_d;

    // Sticky range flag: cleared on start, set by any out-of-range handshaken coefficient.
    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && start) begin
            err_d = 1'b0;
        end else if (state_q == S_RUN && coeff_hs && ELL == 12
                     && 32'(coeff_q) >= 32'(MODQ)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
